// File: rtl/vga_sync_gen.sv
// VGA raster timing: registered x/y position with aligned sync, blanking,
// line/frame strobes and a free-running frame counter.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_d, x_q;
    logic [9:0] y_d, y_q;
    logic       hsync_d, hsync_q;
    logic       vsync_d, vsync_q;
    logic       disp_d, disp_q;
    logic       line_d, line_q;
    logic       frame_d, frame_q;
    logic [7:0] fcnt_d, fcnt_q;

    // Decode from the next position so every output describes the same pixel.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        disp_d  = disp_q;
        line_d  = 1'b0;
        frame_d = 1'b0;
        fcnt_d  = fcnt_q;
        if (pix_en) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
            hsync_d = (x_d >= HS_BEG && x_d < HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync_d = (y_d >= VS_BEG && y_d < VS_END) ? SYNC_POL : ~SYNC_POL;
            disp_d  = (x_d < H_VIS) && (y_d < V_VIS);
            line_d  = (x_d == '0);
            frame_d = line_d && (y_d == '0);
            fcnt_d  = fcnt_q + {7'd0, frame_d};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= H_LAST;
            y_q     <= V_LAST;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            disp_q  <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            disp_q  <= disp_d;
            line_q  <= line_d;
            frame_q <= frame_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = disp_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;
    assign frame_count = fcnt_q;

endmodule
